// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache line misses onto one 4-beat pmem burst port.
// Optional CACHE_ARB_RR_EN: round-robin instead of fixed D > I.
module cache_mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int BW    = $clog2(BEATS);
  localparam int OFS   = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE, I_RD, D_RD, D_WR, RESP
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state;
  logic [BW-1:0]       beat;
  logic                owner;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   fill;
  logic [ADDR_W-1:0]   req_addr;
  logic                d_req;
  logic                grant_d;
  logic                grant_i;
  logic                last_beat;
  logic                unused_bits;

  assign d_req       = d_read | d_write;
  assign last_beat   = beat == BW'(BEATS - 1);
  assign unused_bits = ^{i_address[OFS-1:0], d_address[OFS-1:0]};

`ifdef CACHE_ARB_RR_EN
  logic last_owner;
  // On contention, favour whoever was not served last.
  assign grant_d = d_req & (!i_read | last_owner == OWN_I);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_read & !grant_d;

  always_comb begin
    req_addr = grant_d ? d_address : i_address;
    fill     = line_q;
    fill[beat*BURST_W +: BURST_W] = pmem_rdata;
  end

  assign pmem_wdata = pmem_write ?
    line_q[beat*BURST_W +: BURST_W] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      owner        <= OWN_I;
      line_q       <= '0;
      i_rdata      <= '0;
      i_resp       <= 1'b0;
      d_rdata      <= '0;
      d_resp       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d | grant_i) begin
            pmem_address <= {req_addr[ADDR_W-1:OFS], OFS'(0)};
            beat         <= '0;
            owner        <= grant_d;
            if (grant_d & d_write) begin
              line_q     <= d_wdata;
              pmem_write <= 1'b1;
              state      <= D_WR;
            end else begin
              pmem_read <= 1'b1;
              state     <= grant_d ? D_RD : I_RD;
            end
          end
        end
        I_RD, D_RD: begin
          if (pmem_resp) begin
            line_q <= fill;
            beat   <= beat + 1'b1;
            if (last_beat) begin
              pmem_read <= 1'b0;
              state     <= RESP;
              if (owner == OWN_D) begin
                d_resp  <= 1'b1;
                d_rdata <= fill;
              end else begin
                i_resp  <= 1'b1;
                i_rdata <= fill;
              end
            end
          end
        end
        D_WR: begin
          if (pmem_resp) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              pmem_write <= 1'b0;
              state      <= RESP;
              d_resp     <= 1'b1;
              d_rdata    <= line_q;
            end
          end
        end
        RESP: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_owner <= OWN_I;
    else if (state == IDLE && (grant_d | grant_i))
      last_owner <= grant_d;
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; pmem beats driven by hand.
// Honours CACHE_ARB_RR_EN when picking expected grant order.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata, pmem_rdata;

  int vecs = 0;
  int errs = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] LINE_A = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_W = {
    64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] LINE_B = {
    64'h8888_0000_0000_0004, 64'h7777_0000_0000_0003,
    64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001};
  localparam logic [255:0] LINE_C = {
    64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
    64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0;
    pmem_resp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (pmem_read | pmem_write) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Drives four beats starting at the current negedge; ends in RESP.
  task automatic run_beats(input logic [255:0] line,
                           output logic [255:0] wseen,
                           output bit held);
    held = 1'b1;
    wseen = '0;
    for (int b = 0; b < 4; b++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = line[b*64 +: 64];
      wseen[b*64 +: 64] = pmem_wdata;
      held &= (pmem_read | pmem_write);
      @(negedge clk);
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = 0; d_address = 0; d_wdata = 0;
    pmem_resp = 0; pmem_rdata = 0;
    @(negedge clk);
    vecs++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b want 0000",
        {pmem_read, pmem_write, i_resp, d_resp});
    end
    vecs++;
    if (i_rdata !== '0 || d_rdata !== '0 || pmem_address !== 0) begin
      errs++;
      $display("FAIL reset_data i=%h d=%h a=%h want 0",
        i_rdata, d_rdata, pmem_address);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    bit ok, held;
    logic [255:0] w;
    i_read = 1'b1;
    i_address = 32'h6000_0024;
    @(negedge clk);
    vecs++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h6000_0020) begin
      errs++;
      $display("FAIL i_grant rd=%b a=%h want 1 60000020",
        pmem_read, pmem_address);
    end
    run_beats(LINE_A, w, held);
    vecs++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errs++;
      $display("FAIL i_resp got i=%b d=%b rd=%b want 1 0 0",
        i_resp, d_resp, pmem_read);
    end
    vecs++;
    if (i_rdata !== LINE_A) begin
      errs++;
      $display("FAIL i_rdata got %h want %h", i_rdata, LINE_A);
    end
    i_read = 1'b0;
    @(negedge clk);
    vecs++;
    if (i_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errs++;
      $display("FAIL i_pulse got resp=%b rd=%b want 0 0",
        i_resp, pmem_read);
    end
    ok = held;
  endtask

  task automatic test_d_write();
    bit ok, held;
    logic [255:0] w;
    d_write = 1'b1;
    d_address = 32'h8000_0040;
    d_wdata = LINE_W;
    @(negedge clk);
    wait_busy(ok);
    vecs++;
    if (!ok || pmem_write !== 1'b1 || pmem_read !== 1'b0 ||
        pmem_address !== 32'h8000_0040) begin
      errs++;
      $display("FAIL wr_grant w=%b r=%b a=%h want 1 0 80000040",
        pmem_write, pmem_read, pmem_address);
    end
    d_wdata = '0;
    run_beats('0, w, held);
    vecs++;
    if (w !== LINE_W || !held) begin
      errs++;
      $display("FAIL wr_beats got %h held=%b want %h held=1",
        w, held, LINE_W);
    end
    vecs++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || pmem_write !== 1'b0) begin
      errs++;
      $display("FAIL wr_resp got d=%b i=%b w=%b want 1 0 0",
        d_resp, i_resp, pmem_write);
    end
    d_write = 1'b0;
    @(negedge clk);
    vecs++;
    if (d_resp !== 1'b0) begin
      errs++;
      $display("FAIL wr_pulse got %b want 0", d_resp);
    end
  endtask

  task automatic test_contention();
    bit ok, held;
    logic [255:0] w;
    do_reset();
    i_read = 1'b1; i_address = 32'h1000_0045;
    d_read = 1'b1; d_address = 32'h2000_009F;
    @(negedge clk);
    wait_busy(ok);
    vecs++;
    if (!ok || pmem_address !== 32'h2000_0080) begin
      errs++;
      $display("FAIL arb_first a=%h want 20000080", pmem_address);
    end
    run_beats(LINE_B, w, held);
    vecs++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== LINE_B) begin
      errs++;
      $display("FAIL arb_d d=%b i=%b data=%h want 1 0 %h",
        d_resp, i_resp, d_rdata, LINE_B);
    end
    d_read = 1'b0;
    @(negedge clk);
    wait_busy(ok);
    vecs++;
    if (!ok || pmem_address !== 32'h1000_0040) begin
      errs++;
      $display("FAIL arb_second a=%h want 10000040", pmem_address);
    end
    run_beats(LINE_C, w, held);
    vecs++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== LINE_C) begin
      errs++;
      $display("FAIL arb_i i=%b d=%b data=%h want 1 0 %h",
        i_resp, d_resp, i_rdata, LINE_C);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternation();
    bit ok, held;
    bit is_d, want_d;
    logic [255:0] w;
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
`ifdef CACHE_ARB_RR_EN
      want_d = (g % 2) == 0;
`else
      want_d = 1'b1;
`endif
      wait_busy(ok);
      is_d = pmem_address == 32'h0000_2000;
      vecs++;
      if (!ok || is_d !== want_d) begin
        errs++;
        $display("FAIL alt_grant%0d got d=%b a=%h want d=%b",
          g, is_d, pmem_address, want_d);
      end
      run_beats(LINE_A, w, held);
      vecs++;
      if ({d_resp, i_resp} !== {is_d, !is_d}) begin
        errs++;
        $display("FAIL alt_resp%0d got %b want %b",
          g, {d_resp, i_resp}, {is_d, !is_d});
      end
      if (g == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end else if (is_d) d_read = 1'b0;
      else i_read = 1'b0;
      @(negedge clk);
      if (g != 3) begin
        i_read = 1'b1; d_read = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bit ok, held;
    logic [255:0] w;
    d_read = 1'b1; d_address = 32'h3000_0000;
    @(negedge clk);
    wait_busy(ok);
    for (int b = 0; b < 2; b++) begin
      pmem_resp = 1'b1;
      pmem_rdata = 64'hBAD0_0000_0000_0000 + 64'(b);
      @(negedge clk);
    end
    pmem_resp = 1'b0;
    rst = 1'b0;
    #1;
    vecs++;
    if (!ok || pmem_read !== 1'b0) begin
      errs++;
      $display("FAIL rst_async got rd=%b want 0", pmem_read);
    end
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (pmem_read !== 1'b0 || d_resp !== 1'b0) begin
      errs++;
      $display("FAIL rst_idle rd=%b d=%b want 0 0", pmem_read, d_resp);
    end
    i_read = 1'b1; i_address = 32'h4000_0060;
    @(negedge clk);
    wait_busy(ok);
    run_beats(LINE_C, w, held);
    vecs++;
    if (!ok || i_resp !== 1'b1 || i_rdata !== LINE_C) begin
      errs++;
      $display("FAIL rst_refill resp=%b data=%h want 1 %h",
        i_resp, i_rdata, LINE_C);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_resp();
    bit ok, held;
    logic [255:0] w;
    for (int n = 0; n < 3; n++) begin
      pmem_resp = 1'b1;
      pmem_rdata = 64'hFFFF_FFFF_0000_0000 + 64'(n);
      @(negedge clk);
      vecs++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 ||
          i_rdata !== LINE_C) begin
        errs++;
        $display("FAIL idle_resp%0d ctl=%b i=%h want 0000 %h", n,
          {pmem_read, pmem_write, i_resp, d_resp}, i_rdata, LINE_C);
      end
    end
    pmem_resp = 1'b0;
    i_read = 1'b1; i_address = 32'h5000_0000;
    @(negedge clk);
    wait_busy(ok);
    run_beats(LINE_B, w, held);
    vecs++;
    if (!ok || i_resp !== 1'b1 || i_rdata !== LINE_B) begin
      errs++;
      $display("FAIL idle_after resp=%b data=%h want 1 %h",
        i_resp, i_rdata, LINE_B);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_alternation();
    test_reset_mid_burst();
    test_idle_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
